// File: rtl/fft_stream_scheduler.sv
// Shares one FFT engine between NUM_ANT antenna frame buffers: round-robin frame
// grants, N/2-cycle read streams, and a tag FIFO that labels each FFT output frame.
module fft_stream_scheduler #(
    parameter int N            = 64,
    parameter int NUM_ANT      = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int AW  = $clog2(N / 2),
    localparam int IDW = $clog2(NUM_ANT),
    localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1,
    localparam int CW  = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_ANT-1:0] req,
    input  logic               fft_out_valid,
    output logic [NUM_ANT-1:0] grant,
    output logic [AW-1:0]      rd_addr,
    output logic               fft_enable,
    output logic [IDW-1:0]     out_ant_id,
    output logic               out_id_valid,
    output logic               busy,
    output logic               tag_full,
    output logic               err_underflow,
    output logic               dbg_state_o,
    output logic [CW-1:0]      dbg_count_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   win_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   arb_win;
    logic [IDW-1:0]   arb_idx;
    logic             arb_found;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [IDW-1:0]   mem_q [MAX_INFLIGHT];
    logic             push;
    logic             pop;
    logic             empty;

    function automatic logic [IDW-1:0] ant_inc(input logic [IDW-1:0] a);
        return (a == IDW'(NUM_ANT - 1)) ? '0 : a + IDW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Scan starts at the antenna after the last grant, so the previous winner
    // only wins again when nobody else is requesting.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_ANT; i++) begin
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx;
            end
            arb_idx = ant_inc(arb_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant      <= '0;
            fft_enable <= 1'b0;
            rd_addr    <= '0;
            win_q      <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found && !tag_full) begin
                        state_q    <= STREAM;
                        grant      <= NUM_ANT'(1) << arb_win;
                        fft_enable <= 1'b1;
                        rd_addr    <= '0;
                        win_q      <= arb_win;
                        rr_ptr_q   <= ant_inc(arb_win);
                    end
                end
                STREAM: begin
                    if (rd_addr == AW'(N / 2 - 1)) begin
                        state_q    <= IDLE;
                        grant      <= '0;
                        fft_enable <= 1'b0;
                        rd_addr    <= '0;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A frame's tag enters the FIFO on its first stream cycle; the FFT engine
    // returns frames in issue order, so the head always owns the next output.
    assign push  = (state_q == STREAM) && (rd_addr == '0);
    assign empty = (count_q == '0);
    assign pop   = fft_out_valid && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (fft_out_valid && empty) err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= win_q;
    end

    assign out_ant_id   = mem_q[rd_ptr_q];
    assign out_id_valid = pop;
    assign busy         = (state_q == STREAM) || !empty;
    assign tag_full     = (count_q == CW'(MAX_INFLIGHT));
    assign dbg_state_o  = state_q;
    assign dbg_count_o  = count_q;

endmodule

// File: tb/tb_fft_stream_scheduler.sv
// Bench for fft_stream_scheduler: frame-level reference model with a tag queue,
// negedge monitor comparing every output, directed cases and a random phase.
module tb_fft_stream_scheduler;

    localparam int N   = 8;
    localparam int NA  = 4;
    localparam int MI  = 4;
    localparam int AW  = 2;
    localparam int IDW = 2;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NA-1:0] req;
    logic          fft_out_valid;
    logic [NA-1:0] grant;
    logic [AW-1:0] rd_addr;
    logic          fft_enable;
    logic [IDW-1:0] out_ant_id;
    logic          out_id_valid;
    logic          busy;
    logic          tag_full;
    logic          err_underflow;
    logic          dbg_state;
    logic [CW-1:0] dbg_count;

    fft_stream_scheduler #(.N(N), .NUM_ANT(NA), .MAX_INFLIGHT(MI)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .fft_out_valid (fft_out_valid),
        .grant         (grant),
        .rd_addr       (rd_addr),
        .fft_enable    (fft_enable),
        .out_ant_id    (out_ant_id),
        .out_id_valid  (out_id_valid),
        .busy          (busy),
        .tag_full      (tag_full),
        .err_underflow (err_underflow),
        .dbg_state_o   (dbg_state),
        .dbg_count_o   (dbg_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which antenna is streaming, how far into its frame, who
    // is next in round-robin order, and the queue of frames awaiting FFT output.
    logic [IDW-1:0] exp_q[$];
    bit m_stream = 1'b0;
    int m_ant    = 0;
    int m_addr   = 0;
    int m_next   = 0;
    bit m_err    = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_stream = 1'b0;
            m_ant    = 0;
            m_addr   = 0;
            m_next   = 0;
            m_err    = 1'b0;
        end else begin : model_step
            bit full;
            bit new_frame_tag;
            full          = (exp_q.size() == MI);
            new_frame_tag = m_stream && (m_addr == 0);
            if (fft_out_valid) begin
                if (exp_q.size() == 0) m_err = 1'b1;
                else void'(exp_q.pop_front());
            end
            if (new_frame_tag) exp_q.push_back(m_ant[IDW-1:0]);
            if (m_stream) begin
                if (m_addr == N / 2 - 1) begin
                    m_stream = 1'b0;
                    m_addr   = 0;
                end else begin
                    m_addr++;
                end
            end else if (req != 0 && !full) begin
                for (int i = 0; i < NA; i++) begin
                    if (req[(m_next + i) % NA]) begin
                        m_ant = (m_next + i) % NA;
                        break;
                    end
                end
                m_stream = 1'b1;
                m_addr   = 0;
                m_next   = (m_ant + 1) % NA;
            end
        end
    end

    logic [NA-1:0] grant_log[$];
    logic [IDW-1:0] id_log[$];
    logic [NA-1:0] prev_grant = '0;

    always @(negedge clk) begin : monitor
        bit exp_ov;
        check("grant", grant, m_stream ? (32'd1 << m_ant) : 32'd0);
        check("fft_enable", fft_enable, m_stream);
        check("rd_addr", rd_addr, m_addr);
        check("busy", busy, m_stream || exp_q.size() > 0);
        check("tag_full", tag_full, exp_q.size() == MI);
        check("err_underflow", err_underflow, m_err);
        check("tag_count", dbg_count, exp_q.size());
        check("fsm_state", dbg_state, m_stream);
        exp_ov = fft_out_valid && (exp_q.size() > 0);
        check("out_id_valid", out_id_valid, exp_ov);
        if (exp_ov) check("out_ant_id", out_ant_id, exp_q[0]);
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
        if (out_id_valid) id_log.push_back(out_ant_id);
        prev_grant = grant;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        fft_out_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        req = '0;
        for (int i = 0; i < 60; i++) begin
            fft_out_valid = (exp_q.size() > 0);
            step();
        end
        fft_out_valid = 1'b0;
        check("drained", exp_q.size(), 0);
    endtask

    task automatic wait_cond_full_idle();
        for (int i = 0; i < 60; i++) begin
            if (tag_full && !fft_enable) return;
            step();
        end
        check("wait_full_idle_timeout", 0, 1);
    endtask

    initial begin
        int guard;
        req = '0;
        fft_out_valid = 1'b0;
        #1 reset = 1'b1;
        step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tag_full", tag_full, 0);
        check("rst_err", err_underflow, 0);
        step();
        reset = 1'b0;

        // single requester streams back-to-back frames
        req = 4'b0001;
        grant_log.delete();
        repeat (11) step();
        check("single_frames", grant_log.size() >= 2, 1);
        if (grant_log.size() >= 2) begin
            check("single_g0", grant_log[0], 4'b0001);
            check("single_g1", grant_log[1], 4'b0001);
        end
        drain();

        // all requesting: rotation and tag order
        do_reset();
        grant_log.delete();
        id_log.delete();
        req = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            fft_out_valid = (exp_q.size() >= 2);
            step();
        end
        drain();
        check("rr_len", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5) begin
            check("rr_g0", grant_log[0], 4'b0001);
            check("rr_g1", grant_log[1], 4'b0010);
            check("rr_g2", grant_log[2], 4'b0100);
            check("rr_g3", grant_log[3], 4'b1000);
            check("rr_g4", grant_log[4], 4'b0001);
        end
        check("tag_len", id_log.size() >= 4, 1);
        if (id_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("tag_order", id_log[i], i);
        end

        // tag FIFO full stalls arbitration until one output frame retires
        do_reset();
        req = 4'b1111;
        wait_cond_full_idle();
        repeat (3) step();
        check("full_flag", tag_full, 1);
        check("full_no_grant", grant, 0);
        fft_out_valid = 1'b1;
        @(negedge clk);
        check("full_pop_id", out_ant_id, 0);
        check("full_pop_vld", out_id_valid, 1);
        @(posedge clk);
        #1;
        fft_out_valid = 1'b0;
        step();
        check("full_resume_grant", grant, 4'b0001);
        drain();

        // push and pop in the same cycle with two tags held
        do_reset();
        req = 4'b0011;
        guard = 0;
        while (!(m_stream && m_addr == 0 && exp_q.size() == 2) && guard < 40) begin
            step();
            guard++;
        end
        check("pp_reached", guard < 40, 1);
        check("pp_count_before", dbg_count, 2);
        fft_out_valid = 1'b1;
        @(negedge clk);
        check("pp_head_id", out_ant_id, 0);
        @(posedge clk);
        #1;
        fft_out_valid = 1'b0;
        check("pp_count_after", dbg_count, 2);
        drain();

        // underflow is sticky until reset
        do_reset();
        fft_out_valid = 1'b1;
        @(negedge clk);
        check("uf_no_valid", out_id_valid, 0);
        @(posedge clk);
        #1;
        fft_out_valid = 1'b0;
        check("uf_set", err_underflow, 1);
        repeat (5) step();
        check("uf_sticky", err_underflow, 1);
        do_reset();
        check("uf_cleared", err_underflow, 0);

        // reset mid-frame aborts at once
        req = 4'b0010;
        guard = 0;
        while (rd_addr != 2 && guard < 20) begin
            step();
            guard++;
        end
        check("mid_reached", guard < 20, 1);
        reset = 1'b1;
        #1;
        check("mid_grant", grant, 0);
        check("mid_enable", fft_enable, 0);
        check("mid_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        check("mid_regrant", grant, 4'b0010);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            fft_out_valid = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();

        req = '0;
        fft_out_valid = 1'b0;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stream_scheduler.md
FFT_STREAM_SCHEDULER -- requirements
Module: fft_stream_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 64: FFT size; power of two, 8..4096.
REQ-002 The block SHALL have parameter NUM_ANT, default 4: number of antenna frame buffers sharing one FFT engine; 2..8.
REQ-003 The block SHALL have parameter MAX_INFLIGHT, default 4: depth of the tag FIFO, i.e. the maximum number of frames issued but not yet output; power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_ANT bits: bit k high means antenna k holds a complete N-sample frame.
REQ-007 The block SHALL have port fft_out_valid, input, 1 bit: the FFT engine out_valid, one pulse per completed frame.
REQ-008 The block SHALL have port grant, output, NUM_ANT bits: one-hot select of the antenna buffer and data mux feeding the FFT engine.
REQ-009 The block SHALL have port rd_addr, output, $clog2(N/2) bits: sample-pair index within the granted frame.
REQ-010 The block SHALL have port fft_enable, output, 1 bit: drives the FFT engine enable.
REQ-011 The block SHALL have port out_ant_id, output, $clog2(NUM_ANT) bits: antenna that owns the frame currently on the FFT output.
REQ-012 The block SHALL have port out_id_valid, output, 1 bit: out_ant_id is qualified this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: the FSM is in STREAM or the tag FIFO is non-empty.
REQ-014 The block SHALL have port tag_full, output, 1 bit: the tag FIFO holds MAX_INFLIGHT entries.
REQ-015 The block SHALL have port err_underflow, output, 1 bit: sticky flag, set when fft_out_valid arrives with the tag FIFO empty.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and STREAM; the reset state SHALL be IDLE.
REQ-017 In IDLE, if req is non-zero and tag_full is low, the block SHALL select a winner round-robin, starting at the index after the last granted antenna (antenna 0 first after reset), and enter STREAM on the next cycle.
REQ-018 In IDLE, if tag_full is high, the block SHALL not arbitrate and SHALL hold every req pending.
REQ-019 In STREAM, grant SHALL be the winner's one-hot, fft_enable SHALL be 1, and rd_addr SHALL count from 0 to N/2-1, advancing by one per cycle.
REQ-020 STREAM SHALL last exactly N/2 cycles; after the cycle with rd_addr = N/2-1 the block SHALL return to IDLE, giving N/2+1 cycles per frame when requests are back-to-back.
REQ-021 In IDLE, grant SHALL be 0, fft_enable SHALL be 0 and rd_addr SHALL be 0.
REQ-022 Deassertion of req during STREAM SHALL be ignored; the frame SHALL always complete.
REQ-023 Antenna k SHALL treat the falling edge of grant[k] as frame consumed; the block SHALL not re-grant k in the same IDLE cycle unless k is the only requester.
REQ-024 On the first STREAM cycle, the winner index SHALL be pushed into the tag FIFO.
REQ-025 On each fft_out_valid with the FIFO non-empty, the head entry SHALL be popped; out_ant_id SHALL equal that head entry in the same cycle, and out_id_valid SHALL equal fft_out_valid combinationally.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving the FIFO count unchanged.
REQ-027 fft_out_valid with the FIFO empty SHALL set err_underflow, leave the FIFO count unchanged, and hold out_id_valid at 0.
REQ-028 The round-robin pointer SHALL wrap from NUM_ANT-1 to 0.

Reset
REQ-029 While reset is high, all state SHALL clear asynchronously: FSM to IDLE, rd_addr to 0, grant to 0, fft_enable to 0, FIFO to empty, round-robin pointer to antenna 0, err_underflow to 0, busy to 0 and tag_full to 0.
REQ-030 A reset asserted mid-STREAM SHALL abort the frame immediately and discard all in-flight tags; the FFT engine is reset by the same signal.

Verification
REQ-031 Bench case: N=8, req=0001 held -> grant=0001 for 4 cycles with rd_addr 0,1,2,3, then one idle cycle, then repeats.
REQ-032 Bench case: req=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, and the tag FIFO records ids 0,1,2,3.
REQ-033 Bench case: MAX_INFLIGHT=4, four frames issued with no fft_out_valid -> tag_full=1, grant stays 0 with req still high; one fft_out_valid pulse -> out_ant_id=0 and the next frame starts within 2 cycles.
REQ-034 Bench case: push and fft_out_valid in the same cycle with count=2 -> count stays 2 and out_ant_id equals the oldest tag.
REQ-035 Bench case: fft_out_valid with the FIFO empty -> err_underflow=1 and stays 1 until reset; out_id_valid=0.
REQ-036 Bench case: reset at rd_addr=2 -> grant=0, fft_enable=0, busy=0 on the same edge; after release with req=0010, grant=0010 on the next cycle.
